// File: rtl/fifo_out_drain_ctrl.sv
// fifo_out_drain_ctrl: bus-master sequencer that drains the result FIFO slave
// into the local result memory. It polls the flag register, pops one word
// whenever the FIFO is non-empty, and writes it at an incrementing address.
// It stops when the programmed count is reached, when the poll timeout
// expires, when abort is seen, or when the FIFO reports a read error.
module fifo_out_drain_ctrl #(
  parameter int MEM_AW  = 8,
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic [MEM_AW-1:0] cfg_base,
  output logic              m_sel,
  output logic              m_wr,
  output logic [7:0]        m_address,
  input  logic [31:0]       m_din,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  words_done
);

  typedef enum logic [2:0] {
    IDLE, POLL, POLL_WAIT, READ, READ_WAIT, FIN
  } state_t;

  localparam logic [7:0]        ADDR_FLAG = 8'h20;
  localparam logic [7:0]        ADDR_DATA = 8'h21;
  localparam logic [7:0]        TMO_LIM   = 8'(TIMEOUT);
  localparam logic [7:0]        TMO_ONE   = 8'd1;
  localparam logic [MEM_AW-1:0] ADDR_ONE  = MEM_AW'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_TMO   = 2'b01;
  localparam logic [1:0] ST_ABORT = 2'b10;
  localparam logic [1:0] ST_RDERR = 2'b11;

  state_t            state_q, state_d;
  logic [MEM_AW-1:0] addr_q;
  logic [CNT_W-1:0]  rem_q;
  logic [7:0]        tmo_q;

  // Flag decode; only meaningful in POLL_WAIT when m_din carries the flag word.
  logic flag_rd_err, flag_empty, tmo_hit, last_word;
  assign flag_rd_err = m_din[0];
  assign flag_empty  = m_din[4];
  assign tmo_hit     = ((tmo_q + TMO_ONE) == TMO_LIM);
  assign last_word   = (rem_q == CNT_ONE);

  // State register; reset drops straight to IDLE with no done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: zero-count start goes straight to FIN to pulse done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = (cfg_count != '0) ? POLL : FIN;
      POLL:      state_d = POLL_WAIT;
      POLL_WAIT: begin
        if (flag_rd_err)     state_d = FIN;
        else if (abort)      state_d = FIN;
        else if (flag_empty) state_d = tmo_hit ? FIN : POLL;
        else                 state_d = READ;
      end
      READ:      state_d = READ_WAIT;
      READ_WAIT: state_d = last_word ? FIN : POLL;
      FIN:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs: bus request decoded from state only; memory write is the
  // combinational pass-through of the popped word during READ_WAIT.
  always_comb begin
    m_sel     = 1'b0;
    m_wr      = 1'b0;
    m_address = 8'h00;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state_q != IDLE);
    done      = (state_q == FIN);
    case (state_q)
      POLL: begin
        m_sel     = 1'b1;
        m_address = ADDR_FLAG;
      end
      READ: begin
        m_sel     = 1'b1;
        m_address = ADDR_DATA;
      end
      READ_WAIT: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = m_din;
      end
      default: ;
    endcase
  end

  // Datapath: address/remaining/timeout counters plus sticky status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      rem_q      <= '0;
      tmo_q      <= '0;
      words_done <= '0;
      status     <= ST_OK;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          words_done <= '0;
          status     <= ST_OK;
          tmo_q      <= '0;
          if (cfg_count != '0) begin
            addr_q <= cfg_base;
            rem_q  <= cfg_count;
          end
        end
        POLL_WAIT: begin
          if (flag_rd_err)   status <= ST_RDERR;
          else if (abort)    status <= ST_ABORT;
          else if (flag_empty) begin
            tmo_q <= tmo_q + TMO_ONE;
            if (tmo_hit) status <= ST_TMO;
          end else           tmo_q <= '0;
        end
        READ_WAIT: begin
          addr_q     <= addr_q + ADDR_ONE;
          rem_q      <= rem_q - CNT_ONE;
          words_done <= words_done + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_out_drain_ctrl.sv
// Bench for fifo_out_drain_ctrl: behavioural FIFO slave, scoreboard queues
// for memory writes and done events, monitor comparing at the falling edge.
module tb_fifo_out_drain_ctrl;

  localparam int MEM_AW = 8;
  localparam int CNT_W  = 6;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CNT_W-1:0]  cfg_count = '0;
  logic [MEM_AW-1:0] cfg_base = '0;
  logic              m_sel, m_wr;
  logic [7:0]        m_address;
  logic [31:0]       m_din = '0;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy, done;
  logic [1:0]        status;
  logic [CNT_W-1:0]  words_done;

  fifo_out_drain_ctrl #(.MEM_AW(MEM_AW), .CNT_W(CNT_W), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_count(cfg_count), .cfg_base(cfg_base),
    .m_sel(m_sel), .m_wr(m_wr), .m_address(m_address), .m_din(m_din),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .status(status), .words_done(words_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic [1:0] st; int wd; int cyc; } dn_t;

  wr_t exp_w[$];
  dn_t exp_d[$];
  logic [31:0] fifo[$];

  int tests = 0, fails = 0;
  int cyc = 0, start_cyc = 0;
  int flag_reads = 0, data_reads = 0, empty_reads = 0, done_cnt = 0;
  logic force_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO slave: answers a one-cycle request on the next clock edge.
  always @(posedge clk) begin
    if (m_sel) begin
      if (m_address == 8'h20) begin
        m_din <= {26'd0, fifo.size() >= 16, fifo.size() == 0, 3'b000, force_err};
        flag_reads <= flag_reads + 1;
        if (fifo.size() == 0) empty_reads <= empty_reads + 1;
      end else if (m_address == 8'h21) begin
        data_reads <= data_reads + 1;
        if (fifo.size() > 0) m_din <= fifo.pop_front();
        else                 m_din <= 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: pops scoreboard entries whenever the DUT writes or finishes.
  always @(negedge clk) begin
    if (reset_n) begin
      if (m_sel) check("m_wr_low", {31'd0, m_wr}, 32'd0);
      if (mem_we) begin
        if (exp_w.size() == 0) check("unexpected_write", {24'd0, mem_addr}, 32'hFFFF_FFFF);
        else begin
          wr_t e;
          e = exp_w.pop_front();
          check("mem_addr", {24'd0, mem_addr}, {24'd0, e.addr});
          check("mem_wdata", mem_wdata, e.data);
          if (e.cyc != 0) check("write_cycle", cyc - start_cyc + 1, e.cyc);
        end
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        if (exp_d.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          dn_t d;
          d = exp_d.pop_front();
          check("status", {30'd0, status}, {30'd0, d.st});
          check("words_done", {26'd0, words_done}, d.wd);
          if (d.cyc != 0) check("done_cycle", cyc - start_cyc + 1, d.cyc);
        end
      end
    end
  end

  task automatic go(input int cnt, input logic [7:0] base);
    @(negedge clk);
    cfg_count = CNT_W'(cnt);
    cfg_base  = base;
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n0 = done_cnt;
    int k  = 0;
    while (done_cnt == n0 && k < 300) begin @(negedge clk); k++; end
    if (done_cnt == n0) check({name, "_done_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    check({name, "_writes_left"}, exp_w.size(), 32'd0);
  endtask

  task automatic wait_read;
    int k = 0;
    while (!(m_sel && m_address == 8'h21) && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) check("read_wait_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int fr, dr, er, k;

    // Reset state
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_msel", {31'd0, m_sel}, 32'd0);
    check("rst_status", {30'd0, status}, 32'd0);
    check("rst_words", {26'd0, words_done}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);

    // 1: three preloaded words, timing 5/9/13, done in cycle 14
    fifo = '{32'h1, 32'h2, 32'h6};
    exp_w.push_back('{8'h10, 32'h1, 5});
    exp_w.push_back('{8'h11, 32'h2, 9});
    exp_w.push_back('{8'h12, 32'h6, 13});
    exp_d.push_back('{2'b00, 3, 14});
    go(3, 8'h10);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_done("t1");

    // 2: empty FIFO, timeout after exactly 4 flag reads
    fr = flag_reads; dr = data_reads;
    exp_d.push_back('{2'b01, 0, 0});
    go(2, 8'h30);
    wait_done("t2");
    check("t2_flag_reads", flag_reads - fr, 32'd4);
    check("t2_data_reads", data_reads - dr, 32'd0);
    check("t2_status_held", {30'd0, status}, 32'd1);

    // 3: words arrive late; 3 empty polls before each, tmo must reset between
    er = empty_reads;
    exp_w.push_back('{8'h40, 32'hA, 0});
    exp_w.push_back('{8'h41, 32'hB, 0});
    exp_d.push_back('{2'b00, 2, 0});
    go(2, 8'h40);
    k = 0;
    while (empty_reads - er < 3 && k < 100) begin @(negedge clk); k++; end
    fifo.push_back(32'hA);
    k = 0;
    while (empty_reads - er < 6 && k < 100) begin @(negedge clk); k++; end
    fifo.push_back(32'hB);
    wait_done("t3");

    // 4: address wrap; a start while busy is ignored
    fifo = '{32'hC1, 32'hC2};
    exp_w.push_back('{8'hFF, 32'hC1, 5});
    exp_w.push_back('{8'h00, 32'hC2, 9});
    exp_d.push_back('{2'b00, 2, 10});
    go(2, 8'hFF);
    @(negedge clk);
    cfg_count = 6'd5; cfg_base = 8'h77; start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done("t4");

    // 5: abort during READ of word 1 of 4
    fifo = '{32'h11, 32'h12, 32'h13, 32'h14};
    dr = data_reads;
    exp_w.push_back('{8'h80, 32'h11, 5});
    exp_d.push_back('{2'b10, 1, 0});
    go(4, 8'h80);
    wait_read();
    abort = 1'b1;
    wait_done("t5");
    abort = 1'b0;
    check("t5_data_reads", data_reads - dr, 32'd1);
    fifo.delete();

    // 6: FIFO read error flag terminates without a pop
    fifo = '{32'h99};
    force_err = 1'b1;
    dr = data_reads;
    exp_d.push_back('{2'b11, 0, 0});
    go(1, 8'h50);
    wait_done("t6");
    force_err = 1'b0;
    check("t6_data_reads", data_reads - dr, 32'd0);
    repeat (3) @(negedge clk);
    check("t6_status_held", {30'd0, status}, 32'd3);
    fifo.delete();

    // 7: zero count -> done in the next cycle, no bus traffic
    fr = flag_reads; dr = data_reads;
    exp_d.push_back('{2'b00, 0, 2});
    go(0, 8'h00);
    wait_done("t7");
    check("t7_bus_reads", (flag_reads - fr) + (data_reads - dr), 32'd0);

    // 8: reset during READ_WAIT, then a clean one-word transfer
    fifo = '{32'h55};
    go(1, 8'h20);
    wait_read();
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("t8_mem_we", {31'd0, mem_we}, 32'd0);
    check("t8_busy", {31'd0, busy}, 32'd0);
    check("t8_done", {31'd0, done}, 32'd0);
    check("t8_words", {26'd0, words_done}, 32'd0);
    check("t8_mem_addr", {24'd0, mem_addr}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    fifo = '{32'h77};
    exp_w.push_back('{8'h30, 32'h77, 5});
    exp_d.push_back('{2'b00, 1, 6});
    go(1, 8'h30);
    wait_done("t8");

    repeat (4) @(negedge clk);
    check("final_exp_done_left", exp_d.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_out_drain_ctrl.md
Name: fifo_out_drain_ctrl

Overview:
Bus-master sequencer that empties the result output FIFO slave into a local result memory with no host intervention. On a start pulse it polls the FIFO flag register (bus address 0x20). Whenever the FIFO is non-empty it pops one word from the FIFO data port (0x21) and writes it to memory at an incrementing address, until a programmed word count is moved, a poll timeout expires or an abort arrives. It sits between the factorial result FIFO slave and the result RAM, and replaces host polling.

Parameters:
MEM_AW, 8, result memory address width
CNT_W, 6, width of word-count / remaining counter (max 63 words)
TIMEOUT, 255, consecutive empty polls tolerated before timeout termination (1..255)

Ports:
clk  input  1  clock
reset_n  input  1  reset; asynchronous, active-low
start  input  1  single-cycle pulse; accepted only in IDLE
abort  input  1  level; terminates transfer at next word boundary
cfg_count  input  CNT_W  words to move; sampled on accepted start
cfg_base  input  MEM_AW  first memory write address; sampled on accepted start
m_sel  output  1  bus select to FIFO slave
m_wr  output  1  bus direction; held 0 (read only)
m_address  output  8  bus address, 0x20 flag register / 0x21 FIFO data
m_din  input  32  slave read data; valid the cycle after the request cycle
mem_we  output  1  memory write strobe
mem_addr  output  MEM_AW  memory write address
mem_wdata  output  32  memory write data
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on entry to IDLE after a transfer
status  output  2  00 ok, 01 timeout, 10 aborted, 11 FIFO read error; held until next accepted start
words_done  output  CNT_W  words written in current/last transfer

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; internal address/remaining/timeout counters 0.
- Slave contract: request asserted for exactly one cycle (m_sel=1, m_wr=0, m_address). Response on m_din is sampled in the following cycle. m_sel is 0 in all other cycles, so the slave never sees a back-to-back pop.
- Flag word bit map: [5] full, [4] empty, [3] wr_ack, [2] wr_err, [1] rd_ack, [0] rd_err.
- FSM:
  - IDLE: start=1 and cfg_count!=0 -> latch cfg_base to addr_q and cfg_count to rem_q; clear words_done, status and tmo_q; go to POLL. start with cfg_count=0 -> done pulse next cycle, status 00, no bus traffic. start while busy is ignored.
  - POLL: drive m_address=0x20, m_sel=1. Go to POLL_WAIT.
  - POLL_WAIT: sample m_din.
    - bit0=1: status=11, go to FIN.
    - else abort=1: status=10, go to FIN.
    - else bit4=1: tmo_q+1. If tmo_q+1==TIMEOUT, status=01 and go to FIN; otherwise go to POLL.
    - else (non-empty): tmo_q=0, go to READ.
  - READ: drive m_address=0x21, m_sel=1 (pops one word). Go to READ_WAIT.
  - READ_WAIT: mem_we=1, mem_addr=addr_q, mem_wdata=m_din, all combinational this cycle. Then addr_q+1 (wraps modulo 2^MEM_AW), rem_q-1, words_done+1. If rem_q-1==0 go to FIN, else go to POLL.
  - FIN: done=1 for one cycle, go to IDLE.
- Throughput: 4 cycles per word when the FIFO is non-empty. Latency from start to first mem_we is 5 cycles (start edge + POLL + POLL_WAIT + READ + READ_WAIT).
- abort is checked only in POLL_WAIT. A READ already issued always completes its memory write, so no data word is lost.
- A full flag (bit5) is informational only; the transfer continues normally.
- start and abort asserted in the same cycle in IDLE: start is accepted; abort is honoured at the first POLL_WAIT.
- reset_n asserted mid-transfer: immediate return to IDLE with outputs 0 and no done pulse. Words already written stay in memory.
- No combinational path from m_din to m_sel or m_address; both are decoded from state only.

Test Plan:
- FIFO preloaded with 3 words 0x1, 0x2, 0x6; start with count=3, base=0x10 -> mem writes (0x10,0x1),(0x11,0x2),(0x12,0x6) on cycles 5, 9, 13 after start; done pulse; status=00; words_done=3.
- FIFO empty, TIMEOUT=4, count=2 -> exactly 4 flag reads at 0x20, no 0x21 access, no mem_we; status=01; words_done=0.
- FIFO holds 1 word, a second word is pushed 20 cycles later, count=2 -> repeated polls in between; both words written; tmo_q reset after the first word; status=00.
- base=0xFF, count=2, MEM_AW=8 -> writes to 0xFF then 0x00 (wrap).
- abort raised during the READ of word 1 of 4 -> word 1 still written; next POLL_WAIT ends the transfer; status=10; words_done=1; no further 0x21 access.
- reset_n pulsed low in READ_WAIT -> outputs 0 immediately; no done pulse. A subsequent start with count=1 behaves per test 1.
